// File: rtl/bwc_pkg.sv
// Shared definitions for the bank write controller: FSM state codes and the
// ASCII bytes that make up a command frame.
package bwc_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_GOT_BANK = 3'd1,
        S_GOT_CMD  = 3'd2,
        S_DATA     = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    // Plain-vector aliases of the state codes for the FSM register.
    localparam logic [2:0] ST_IDLE     = S_IDLE;
    localparam logic [2:0] ST_GOT_BANK = S_GOT_BANK;
    localparam logic [2:0] ST_GOT_CMD  = S_GOT_CMD;
    localparam logic [2:0] ST_DATA     = S_DATA;
    localparam logic [2:0] ST_DONE     = S_DONE;

    localparam logic [7:0] CMD_W      = 8'h77;
    localparam logic [7:0] CMD_LF     = 8'h0A;
    localparam logic [7:0] DIGIT_BASE = 8'h31;

    // Index width that stays legal (>= 1 bit) when only one item exists.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bank_write_controller_if.sv
// UART byte input and bank write port of the bank write controller.
interface bank_write_controller_if #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned N_BANKS = 2
);
    logic [7:0]         byte_received;
    logic               rx_data_ready;
    logic [N_BANKS-1:0] en;
    logic               we;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  din;
    logic [2:0]         status;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output byte_received, rx_data_ready,
        input  en, we, addr, din, status, busy, done, err
    );

    modport slave (
        input  byte_received, rx_data_ready,
        output en, we, addr, din, status, busy, done, err
    );
endinterface

// File: rtl/bwc_byte_packer.sv
// Assembles little-endian bytes into DATA_W-bit words; the completed word is
// presented combinationally on the cycle its last byte arrives.
module bwc_byte_packer
    import bwc_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_in,
    output logic              word_complete,
    output logic [DATA_W-1:0] word
);
    localparam int unsigned LANES  = DATA_W / 8;
    localparam int unsigned LANE_W = idx_w(LANES);

    logic [LANE_W-1:0] lane_q, lane_d;
    logic [DATA_W-1:0] partial_q, partial_d;

    // The incoming byte is merged in directly so a full word needs no extra cycle.
    always_comb begin
        word = partial_q;
        word[8*int'(lane_q) +: 8] = byte_in;
    end

    assign word_complete = byte_valid && (32'(lane_q) == LANES - 1);

    always_comb begin
        lane_d    = lane_q;
        partial_d = partial_q;
        if (clear) begin
            lane_d = '0;
        end else if (byte_valid) begin
            partial_d = word;
            lane_d    = word_complete ? '0 : lane_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lane_q    <= '0;
            partial_q <= '0;
        end else begin
            lane_q    <= lane_d;
            partial_q <= partial_d;
        end
    end

endmodule

// File: rtl/bank_write_controller.sv
// Parses "<digit> w LF" command frames from a UART byte stream and streams the
// following bytes as words into the selected bank, with an inter-byte timeout.
module bank_write_controller
    import bwc_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned N_BANKS     = 2,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic                    clk,
    input  logic                    rst,
    bank_write_controller_if.slave  bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned BANK_W = idx_w(N_BANKS);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]         state_q, state_d;
    logic [BANK_W-1:0]  bank_q, bank_d;
    logic [ADDR_W-1:0]  waddr_q, waddr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  din_q, din_d;
    logic [N_BANKS-1:0] en_q, en_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               rx;
    logic               digit_ok;
    logic               pack_valid;
    logic               pack_clear;
    logic               word_complete;
    logic [DATA_W-1:0]  word;

    assign rx         = bus.rx_data_ready;
    assign digit_ok   = (bus.byte_received >= DIGIT_BASE) &&
                        (32'(bus.byte_received) < 32'(DIGIT_BASE) + N_BANKS);
    assign pack_valid = (state_q == ST_DATA) && rx;
    assign pack_clear = (state_q == ST_GOT_CMD) && rx && (bus.byte_received == CMD_LF);

    bwc_byte_packer #(.DATA_W(DATA_W)) u_packer (
        .clk           (clk),
        .rst           (rst),
        .clear         (pack_clear),
        .byte_valid    (pack_valid),
        .byte_in       (bus.byte_received),
        .word_complete (word_complete),
        .word          (word)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        state_d = state_q;
        bank_d  = bank_q;
        waddr_d = waddr_q;
        addr_d  = addr_q;
        din_d   = din_q;
        en_d    = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rx && digit_ok) begin
                    bank_d  = BANK_W'(bus.byte_received - DIGIT_BASE);
                    state_d = ST_GOT_BANK;
                end
            end
            ST_GOT_BANK: begin
                if (rx) begin
                    if (bus.byte_received == CMD_W) begin
                        state_d = ST_GOT_CMD;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_GOT_CMD: begin
                if (rx) begin
                    if (bus.byte_received == CMD_LF) begin
                        state_d = ST_DATA;
                        waddr_d = '0;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (rx) begin
                    cnt_d = '0;
                    if (word_complete) begin
                        en_d    = N_BANKS'(1) << bank_q;
                        addr_d  = waddr_q;
                        din_d   = word;
                        waddr_d = waddr_q + 1'b1;
                        // Last word of the bank: finish rather than wrap.
                        if (&waddr_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end else if (32'(cnt_q) >= TIMEOUT_CYC - 1) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            bank_q  <= '0;
            waddr_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            waddr_q <= waddr_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.en     = en_q;
    assign bus.we     = |en_q;
    assign bus.addr   = addr_q;
    assign bus.din    = din_q;
    assign bus.status = state_q;
    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: doc/bank_write_controller.md
BANK_WRITE_CONTROLLER -- requirements
Module: bank_write_controller

Interface
REQ-001 Parameter DATA_W, default 8: memory word width in bits; SHALL be a multiple of 8, range 8..32.
REQ-002 Parameter DEPTH, default 1024: words per bank; SHALL be a power of two, 2..4096.
REQ-003 Parameter N_BANKS, default 2: number of target banks, range 1..9.
REQ-004 Parameter TIMEOUT_CYC, default 65535: idle cycles allowed between data bytes before abort.
REQ-005 Derived constants: ADDR_W = clog2(DEPTH); LANES = DATA_W/8.
REQ-006 Clocking: one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  asynchronous active-low reset.
REQ-009 byte_received  in  8  received UART byte, valid while rx_data_ready=1.
REQ-010 rx_data_ready  in  1  one byte accepted per cycle it is high.
REQ-011 en  out  N_BANKS  one-hot bank enable, asserted only during a write cycle.
REQ-012 we  out  1  write strobe, high exactly when en is nonzero.
REQ-013 addr  out  ADDR_W  word address of the current write.
REQ-014 din  out  DATA_W  word being written.
REQ-015 status  out  3  current FSM state code.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 done  out  1  one-cycle pulse after the final word of a bank is written.
REQ-018 err  out  1  one-cycle pulse on bad command byte or timeout.

Function
REQ-019 FSM states and codes: IDLE=0, GOT_BANK=1, GOT_CMD=2, DATA=3, DONE=4.
REQ-020 Command frame: bank digit ('1'..'0'+N_BANKS, i.e. 0x31..), then 'w' (0x77), then LF (0x0A); digit k selects bank k-1.
REQ-021 IDLE: valid digit -> GOT_BANK with bank latched; any other byte ignored, no err.
REQ-022 GOT_BANK: 'w' -> GOT_CMD; any other byte -> IDLE with err pulse.
REQ-023 GOT_CMD: LF -> DATA, word address cleared to 0, lane index cleared to 0; any other byte -> IDLE with err pulse.
REQ-024 DATA: each accepted byte goes to lane index (lane 0 = bits 7:0, little-endian); lane index increments modulo LANES.
REQ-025 When lane LANES-1 is filled, the write cycle SHALL occur on the next clock: en[bank]=1, we=1, addr=word address, din=assembled word.
REQ-026 The word address increments after each write; a write at addr DEPTH-1 moves the FSM to DONE instead of wrapping.
REQ-027 DONE lasts one cycle: done=1, then IDLE; bytes arriving in DONE are ignored.
REQ-028 Throughput: one byte per clock SHALL be sustained in DATA with no byte lost, including on the cycle a write is issued.
REQ-029 Timeout: a counter clears on every accepted byte in DATA; after TIMEOUT_CYC cycles with no byte -> IDLE with err pulse, partial word discarded, no write.
REQ-030 The timeout counter runs only in DATA and SHALL saturate without wrapping.
REQ-031 Latency: command-byte state changes are visible one cycle after rx_data_ready.
REQ-032 Outside a write cycle en=0, we=0; addr and din hold their last values.

Reset
REQ-033 While rst=0, all state clears immediately: FSM=IDLE, en=0, we=0, addr=0, din=0, done=0, err=0, busy=0, counters and lane index=0.
REQ-034 Reset during DATA aborts the transfer without a write; after release the block waits for a new command frame.

Structure
REQ-035 Package bwc_pkg holds the state enum and the ASCII constants CMD_W=0x77, CMD_LF=0x0A, DIGIT_BASE=0x31.
REQ-036 One sub-module, bwc_byte_packer, handles lane assembly and word-complete indication; the FSM, addressing and timeout stay in the top module.

Verification
REQ-037 DATA_W=8, DEPTH=1024: send 0x32,0x77,0x0A, then 1024 bytes of value i/4 -> 1024 writes with en=2'b10, addr 0..1023, din=i/4, and one done pulse.
REQ-038 DATA_W=32, DEPTH=16: send '1','w',LF, then bytes 0x00..0x3F -> 16 writes on en[0], word 0 = 0x03020100, word 15 = 0x3F3E3D3C.
REQ-039 Send 0x32,0x31 -> err pulse, FSM in IDLE, no write; a following 0x31,0x77,0x0A frame is accepted.
REQ-040 Send bank digit 0x33 with N_BANKS=2 -> ignored, status stays 0, no err.
REQ-041 TIMEOUT_CYC=20: send frame plus 3 bytes with DATA_W=32, then stall 25 cycles -> err pulse at cycle 20, no write, status=0.
REQ-042 Pull rst low after 100 data bytes -> outputs cleared at once, no further writes; a new frame restarts at addr 0.
